// File: rtl/bomb_game_ctrl_pkg.sv
// Shared definitions for the bomb game controller and its tick generator.
package bomb_game_ctrl_pkg;

  localparam int unsigned TIME_W  = 7;
  localparam int unsigned WIRE_W  = 4;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'b000,
    GAME_START = 3'b001,
    GAME_CLEAR = 3'b010,
    GAME_FAIL  = 3'b011
  } state_t;

  localparam logic [TIME_W-1:0] TIME_INIT_DEF = 7'd60;
  localparam logic [TIME_W-1:0] WARN_TIME_DEF = 7'd10;
  localparam logic [1:0]        GOOD_WIRE_DEF = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rising-edge detect; edges are masked
// until the pipeline has refilled after reset so levels already high never fire.
module sync_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       warm_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= 2'd0;
      rise   <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      rise   <= (warm_q == 2'd3) ? (sync_q & ~prev_q) : '0;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb defusal game FSM: start/restart, wire-cut judgement and seconds countdown.
module bomb_game_ctrl
  import bomb_game_ctrl_pkg::*;
#(
  parameter logic [TIME_W-1:0] TIME_INIT = TIME_INIT_DEF,
  parameter logic [1:0]        GOOD_WIRE = GOOD_WIRE_DEF,
  parameter logic [TIME_W-1:0] WARN_TIME = WARN_TIME_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [WIRE_W-1:0]  i_Wire,
  input  logic               i_Sec1Tick,
  output logic [STATE_W-1:0] o_State,
  output logic [TIME_W-1:0]  o_TimeLeft,
  output logic               o_Warn,
  output logic               o_Beep
);

  localparam logic [WIRE_W-1:0] GOOD_MASK = WIRE_W'(1) << GOOD_WIRE;

  logic              start_lvl;
  logic              start_rise;
  logic [WIRE_W-1:0] wire_lvl;
  logic [WIRE_W-1:0] wire_rise;

  sync_edge #(.WIDTH(1)) u_start_sync (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .async_in (i_Start),
    .level    (start_lvl),
    .rise     (start_rise)
  );

  sync_edge #(.WIDTH(WIRE_W)) u_wire_sync (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .async_in (i_Wire),
    .level    (wire_lvl),
    .rise     (wire_rise)
  );

  // A press counts only if the button is still held after its edge (glitch reject).
  logic start_pulse;
  logic bad_cut;
  logic good_cut;

  assign start_pulse = start_rise & start_lvl;
  assign bad_cut     = |(wire_rise & ~GOOD_MASK);
  assign good_cut    = |(wire_rise & GOOD_MASK);

  state_t            state_q;
  state_t            nxt_state;
  logic [TIME_W-1:0] nxt_time;
  logic              nxt_beep;
  logic              nxt_warn;

  always_comb begin
    nxt_state = state_q;
    nxt_time  = o_TimeLeft;
    nxt_beep  = 1'b0;
    case (state_q)
      IDLE: begin
        nxt_time = TIME_INIT;
        if (start_pulse && (wire_lvl == '0)) nxt_state = GAME_START;
      end
      GAME_START: begin
        // Bad cut beats good cut beats tick.
        if (bad_cut) begin
          nxt_state = GAME_FAIL;
        end else if (good_cut) begin
          nxt_state = GAME_CLEAR;
        end else if (i_Sec1Tick && (o_TimeLeft != '0)) begin
          nxt_time = o_TimeLeft - TIME_W'(1);
          nxt_beep = 1'b1;
          if (o_TimeLeft == TIME_W'(1)) nxt_state = GAME_FAIL;
        end
      end
      GAME_CLEAR, GAME_FAIL: begin
        if (start_pulse) begin
          nxt_state = IDLE;
          nxt_time  = TIME_INIT;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_time  = TIME_INIT;
      end
    endcase
    nxt_warn = (nxt_state == GAME_START) && (nxt_time <= WARN_TIME);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= IDLE;
      o_TimeLeft <= TIME_INIT;
      o_Warn     <= 1'b0;
      o_Beep     <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      o_TimeLeft <= nxt_time;
      o_Warn     <= nxt_warn;
      o_Beep     <= nxt_beep;
    end
  end

  assign o_State = state_q;

endmodule
